sdu_rx_avg: RTL and testbench

//  Parametrised coherent-averaging receiver for the SDUltrasound RX path. It accumulates

---
 rtl/sdu_rx_avg_if.sv | 24 ++
 rtl/sdu_rx_avg.sv | 207 ++++++++++++++++++++
 tb/tb_sdu_rx_avg.sv | 222 ++++++++++++++++++++++
 3 files changed

// File: rtl/sdu_rx_avg_if.sv
// sdu_rx_avg_if: averaged-sum output stream towards the PC side
// valid/ready handshake, rx_last marks the final word of a playback
interface sdu_rx_avg_if #(
   parameter int ACC_W = 32
);
   logic [ACC_W-1:0] rx_data;
   logic             rx_valid;
   logic             rx_ready;
   logic             rx_last;

   modport master (
      output rx_data,
      output rx_valid,
      output rx_last,
      input  rx_ready
   );

   modport slave (
      input  rx_data,
      input  rx_valid,
      input  rx_last,
      output rx_ready
   );
endinterface

// File: rtl/sdu_rx_avg.sv
// sdu_rx_avg: coherent-averaging RX receiver, saturating bin-by-bin
// accumulation into an inferred RAM, scaled playback over valid/ready
module sdu_rx_avg #(
   parameter int ADC_W   = 16,
   parameter int ACC_W   = 32,
   parameter int AW      = 12,
   parameter int SHIFT_W = 5
) (
   input  logic               clk,
   input  logic               reset,
   input  logic               rx_en,
   input  logic               seq_done_strobe,
   input  logic               ave_done_strobe,
   input  logic [AW:0]        rec_len,
   input  logic [SHIFT_W-1:0] shift,
   input  logic [ADC_W-1:0]   adc_in,
   input  logic               adc_valid,
   sdu_rx_avg_if.master       rx,
   output logic               busy,
   output logic               done,
   output logic               ovf,
   output logic [15:0]        seq_count
);
   localparam logic [AW:0] DEPTH = {1'b1, {AW{1'b0}}};
   localparam logic [ACC_W-1:0] ACC_MAX = {1'b0, {(ACC_W-1){1'b1}}};
   localparam logic [ACC_W-1:0] ACC_MIN = {1'b1, {(ACC_W-1){1'b0}}};

   typedef enum logic [2:0] {
      IDLE, RECORD, SEQ_DONE, DRAIN1, DRAIN2, READ, PLAYBACK
   } state_t;

   state_t state_q, state_d;
   logic [AW:0]        idx_q, idx_d;
   logic [AW:0]        nb_q, nb_d;
   logic [AW:0]        play_q, play_d;
   logic [SHIFT_W-1:0] shift_q, shift_d;
   logic               first_q, first_d;
   logic [15:0]        seq_q, seq_d;
   logic               ovf_q, ovf_d;
   logic               done_q, done_d;

   logic [ACC_W-1:0] mem [2**AW];
   logic [ACC_W-1:0] rd_q;
   logic             re;
   logic [AW-1:0]    ra;

   logic             s1_v_q, s1_first_q;
   logic [AW-1:0]    s1_addr_q;
   logic [ACC_W-1:0] s1_smp_q;
   logic             s2_v_q;
   logic [AW-1:0]    s2_addr_q;
   logic [ACC_W-1:0] s2_data_q;

   logic             smp;
   logic             last;
   logic             acc;
   logic [AW:0]      play_nx;
   logic [ACC_W:0]   sum;
   logic             clamp;
   logic [ACC_W-1:0] wdata;
   logic signed [ACC_W-1:0] rd_s;

   assign smp = (state_q == RECORD) && adc_valid && (idx_q < nb_q);
   assign last = (play_q == nb_q - 1'b1);
   assign acc = (state_q == PLAYBACK) && rx.rx_ready;
   assign play_nx = play_q + 1'b1;

   always_comb begin
      state_d = state_q;
      idx_d   = idx_q;
      nb_d    = nb_q;
      play_d  = play_q;
      shift_d = shift_q;
      first_d = first_q;
      seq_d   = seq_q;
      ovf_d   = ovf_q;
      done_d  = 1'b0;
      re      = smp;
      ra      = idx_q[AW-1:0];
      unique case (state_q)
         IDLE: begin
            idx_d = '0;
            if (rx_en) begin
               state_d = RECORD;
               if (first_q) begin
                  nb_d  = (rec_len > DEPTH) ? DEPTH : rec_len;
                  ovf_d = 1'b0;
                  seq_d = '0;
               end
            end
         end
         RECORD: begin
            if (smp) idx_d = idx_q + 1'b1;
            if (ave_done_strobe || seq_done_strobe) begin
               if (seq_q != 16'hFFFF) seq_d = seq_q + 16'd1;
            end
            if (ave_done_strobe) begin
               state_d = DRAIN1;
            end else if (seq_done_strobe) begin
               state_d = SEQ_DONE;
               first_d = 1'b0;
            end
         end
         SEQ_DONE: state_d = IDLE;
         DRAIN1:   state_d = DRAIN2;
         DRAIN2:   state_d = READ;
         READ: begin
            re      = 1'b1;
            ra      = '0;
            play_d  = '0;
            shift_d = shift;
            if (nb_q == '0) begin
               state_d = IDLE;
               done_d  = 1'b1;
               first_d = 1'b1;
            end else begin
               state_d = PLAYBACK;
            end
         end
         PLAYBACK: begin
            if (acc) begin
               if (last) begin
                  state_d = IDLE;
                  done_d  = 1'b1;
                  first_d = 1'b1;
               end else begin
                  play_d = play_nx;
                  re     = 1'b1;
                  ra     = play_nx[AW-1:0];
               end
            end
         end
         default: state_d = IDLE;
      endcase
      // a clamp from the accumulate stage outranks any clear
      if (clamp) ovf_d = 1'b1;
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q <= IDLE;
         idx_q   <= '0;
         nb_q    <= '0;
         play_q  <= '0;
         shift_q <= '0;
         first_q <= 1'b1;
         seq_q   <= '0;
         ovf_q   <= 1'b0;
         done_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         idx_q   <= idx_d;
         nb_q    <= nb_d;
         play_q  <= play_d;
         shift_q <= shift_d;
         first_q <= first_d;
         seq_q   <= seq_d;
         ovf_q   <= ovf_d;
         done_q  <= done_d;
      end
   end

   always_comb begin
      sum = {rd_q[ACC_W-1], rd_q} + {s1_smp_q[ACC_W-1], s1_smp_q};
      clamp = 1'b0;
      wdata = sum[ACC_W-1:0];
      if (s1_first_q) begin
         wdata = s1_smp_q;
      end else if (sum[ACC_W] != sum[ACC_W-1]) begin
         wdata = sum[ACC_W] ? ACC_MIN : ACC_MAX;
         clamp = s1_v_q;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         s1_v_q <= 1'b0;
         s2_v_q <= 1'b0;
      end else begin
         s1_v_q <= smp;
         s2_v_q <= s1_v_q;
      end
   end

   always_ff @(posedge clk) begin
      s1_first_q <= first_q;
      s1_addr_q  <= idx_q[AW-1:0];
      s1_smp_q   <= {{(ACC_W-ADC_W){adc_in[ADC_W-1]}}, adc_in};
      s2_addr_q  <= s1_addr_q;
      s2_data_q  <= wdata;
   end

   always_ff @(posedge clk) begin
      if (s2_v_q) mem[s2_addr_q] <= s2_data_q;
      if (re) rd_q <= mem[ra];
   end

   assign rd_s        = rd_q;
   assign rx.rx_valid = (state_q == PLAYBACK);
   assign rx.rx_last  = rx.rx_valid && last;
   assign rx.rx_data  = rx.rx_valid ? ACC_W'(rd_s >>> shift_q) : '0;

   assign busy      = (state_q != IDLE);
   assign done      = done_q;
   assign ovf       = ovf_q;
   assign seq_count = seq_q;
endmodule

// File: tb/tb_sdu_rx_avg.sv
// tb_sdu_rx_avg: table-driven averages plus hand sequences for
// strobe timing, empty records and reset during playback
module tb_sdu_rx_avg;
   localparam int ADC_W   = 16;
   localparam int ACC_W   = 18;
   localparam int AW      = 3;
   localparam int SHIFT_W = 5;

   typedef struct {
      int rec_len;
      int shift;
      int passes;
      bit toggle;
      int smp[8];
      int expw[8];
      int exp_n;
      bit exp_ovf;
   } vec_t;

   logic clk = 1'b0;
   logic reset = 1'b1;
   logic rx_en = 1'b0;
   logic seq_s = 1'b0;
   logic ave_s = 1'b0;
   logic adc_valid = 1'b0;
   logic [AW:0] rec_len = '0;
   logic [SHIFT_W-1:0] shift = '0;
   logic [ADC_W-1:0] adc_in = '0;
   logic busy, done, ovf;
   logic [15:0] seq_count;
   int n_vec = 0;
   int errs = 0;
   vec_t V[11];

   sdu_rx_avg_if #(.ACC_W(ACC_W)) rx();

   sdu_rx_avg #(
      .ADC_W(ADC_W), .ACC_W(ACC_W), .AW(AW), .SHIFT_W(SHIFT_W)
   ) dut (
      .clk(clk),
      .reset(reset),
      .rx_en(rx_en),
      .seq_done_strobe(seq_s),
      .ave_done_strobe(ave_s),
      .rec_len(rec_len),
      .shift(shift),
      .adc_in(adc_in),
      .adc_valid(adc_valid),
      .rx(rx),
      .busy(busy),
      .done(done),
      .ovf(ovf),
      .seq_count(seq_count)
   );

   always #5 clk = ~clk;

   task automatic chk(input string nm, input logic signed [31:0] act,
                      input logic signed [31:0] exp);
      n_vec++;
      if (act !== exp) begin
         errs++;
         $display("FAIL %s: got %0d expected %0d", nm, act, exp);
      end
   endtask

   function automatic logic signed [31:0] wd();
      return 32'($signed(rx.rx_data));
   endfunction

   task automatic feed_avg(input int vi, input bit both);
      for (int p = 0; p < V[vi].passes; p++) begin
         rx_en = 1'b1;
         rec_len = (p == 0) ? (AW+1)'(V[vi].rec_len) : (AW+1)'(1);
         shift = SHIFT_W'(V[vi].shift);
         @(negedge clk);
         rx_en = 1'b0;
         for (int i = 0; i < 8; i++) begin
            adc_valid = 1'b1;
            adc_in = ADC_W'(V[vi].smp[i]);
            if (i == 7) begin
               if (p == V[vi].passes - 1) begin
                  ave_s = 1'b1;
                  seq_s = both;
               end else begin
                  seq_s = 1'b1;
               end
            end
            @(negedge clk);
         end
         adc_valid = 1'b0;
         ave_s = 1'b0;
         seq_s = 1'b0;
         if (p != V[vi].passes - 1) @(negedge clk);
      end
   endtask

   task automatic collect(input int vi);
      int got, cyc;
      bit fin, pst, rdy;
      logic signed [31:0] pd;
      logic pl;
      got = 0; cyc = 0; fin = 0; pst = 0; pd = 0; pl = 0;
      while (!fin && cyc < 300) begin
         if (done) begin
            fin = 1;
         end else begin
            rdy = V[vi].toggle ? bit'(cyc % 2) : 1'b1;
            if (rx.rx_valid && pst) begin
               chk($sformatf("v%0d hold data", vi), wd(), pd);
               chk($sformatf("v%0d hold last", vi), 32'(rx.rx_last), 32'(pl));
            end
            rx.rx_ready = rdy;
            if (rx.rx_valid && rdy) begin
               if (got < V[vi].exp_n) begin
                  chk($sformatf("v%0d word%0d", vi, got), wd(),
                      V[vi].expw[got]);
                  chk($sformatf("v%0d last%0d", vi, got), 32'(rx.rx_last),
                      32'(got == V[vi].exp_n - 1));
               end
               got++;
            end
            pst = rx.rx_valid && !rdy;
            pd = wd();
            pl = rx.rx_last;
            @(negedge clk);
            cyc++;
         end
      end
      if (!fin) chk($sformatf("v%0d done timeout", vi), 0, 1);
      chk($sformatf("v%0d word count", vi), got, V[vi].exp_n);
      chk($sformatf("v%0d seq_count", vi), 32'(seq_count), V[vi].passes);
      chk($sformatf("v%0d ovf", vi), 32'(ovf), 32'(V[vi].exp_ovf));
      rx.rx_ready = 1'b0;
   endtask

   initial begin
      rx.rx_ready = 1'b0;
      V[0] = '{4, 0, 3, 0, '{100, -5, 0, 7, 9, 9, 9, 9},
               '{300, -15, 0, 21, 0, 0, 0, 0}, 4, 0};
      V[1] = '{8, 0, 8, 0, '{32767, 32767, 32767, 32767,
                             32767, 32767, 32767, 32767},
               '{131071, 131071, 131071, 131071,
                 131071, 131071, 131071, 131071}, 8, 1};
      V[2] = '{2, 0, 1, 0, '{1, 2, 0, 0, 0, 0, 0, 0},
               '{1, 2, 0, 0, 0, 0, 0, 0}, 2, 0};
      V[3] = '{3, 2, 4, 1, '{-3, -3, -3, -3, -3, -3, -3, -3},
               '{-3, -3, -3, 0, 0, 0, 0, 0}, 3, 0};
      V[4] = '{13, 0, 2, 0, '{1, 2, 3, 4, 5, 6, 7, 8},
               '{2, 4, 6, 8, 10, 12, 14, 16}, 8, 0};
      V[5] = '{5, 3, 1, 0, '{-100, 100, -1, 8, 32767, 0, 0, 0},
               '{-13, 12, -1, 1, 4095, 0, 0, 0}, 5, 0};
      V[6] = '{2, 0, 8, 0, '{-32768, -32768, 0, 0, 0, 0, 0, 0},
               '{-131072, -131072, 0, 0, 0, 0, 0, 0}, 2, 1};
      V[7] = '{3, 0, 2, 0, '{1000, 2000, 3000, 0, 0, 0, 0, 0},
               '{2000, 4000, 6000, 0, 0, 0, 0, 0}, 3, 0};
      V[8] = '{3, 0, 1, 0, '{5, 6, 7, 0, 0, 0, 0, 0},
               '{5, 6, 7, 0, 0, 0, 0, 0}, 3, 0};
      V[9] = '{2, 0, 1, 0, '{10, 20, 0, 0, 0, 0, 0, 0},
               '{10, 20, 0, 0, 0, 0, 0, 0}, 2, 0};
      V[10] = '{0, 0, 1, 0, '{4, 4, 4, 4, 4, 4, 4, 4},
                '{0, 0, 0, 0, 0, 0, 0, 0}, 0, 0};

      repeat (3) @(negedge clk);
      chk("rst valid", 32'(rx.rx_valid), 0);
      chk("rst last", 32'(rx.rx_last), 0);
      chk("rst data", wd(), 0);
      chk("rst busy", 32'(busy), 0);
      chk("rst done", 32'(done), 0);
      chk("rst ovf", 32'(ovf), 0);
      chk("rst seq", 32'(seq_count), 0);
      reset = 1'b0;
      @(negedge clk);

      for (int v = 0; v < 7; v++) begin
         feed_avg(v, 1'b0);
         collect(v);
      end

      // both strobes together: first word exactly four cycles on
      feed_avg(9, 1'b1);
      for (int k = 0; k < 3; k++) begin
         chk($sformatf("both early valid%0d", k), 32'(rx.rx_valid), 0);
         @(negedge clk);
      end
      chk("both valid T+4", 32'(rx.rx_valid), 1);
      chk("both data T+4", wd(), 10);
      collect(9);

      // empty record: done four cycles on, nothing streamed
      feed_avg(10, 1'b0);
      for (int k = 0; k < 3; k++) begin
         chk($sformatf("empty done early%0d", k), 32'(done), 0);
         chk($sformatf("empty valid%0d", k), 32'(rx.rx_valid), 0);
         @(negedge clk);
      end
      chk("empty done T+4", 32'(done), 1);
      chk("empty valid T+4", 32'(rx.rx_valid), 0);
      @(negedge clk);
      chk("empty done pulse", 32'(done), 0);
      chk("empty busy", 32'(busy), 0);
      chk("empty seq", 32'(seq_count), 1);

      // reset while stalled in playback, then a fresh first pass
      feed_avg(7, 1'b0);
      repeat (5) @(negedge clk);
      chk("stall valid", 32'(rx.rx_valid), 1);
      chk("stall data", wd(), 2000);
      reset = 1'b1;
      @(negedge clk);
      chk("midrst valid", 32'(rx.rx_valid), 0);
      chk("midrst busy", 32'(busy), 0);
      chk("midrst seq", 32'(seq_count), 0);
      reset = 1'b0;
      @(negedge clk);
      feed_avg(8, 1'b0);
      collect(8);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, errs);
      $finish;
   end
endmodule
